rr0: RTL and testbench

Minimal 4-bit accumulator processor for the Cycle demo machine. It has a 16×8 program RAM (loaded by hand through `data_in`/`RAM_button`), a 16×4 data RAM, a 4-bit accumulator and a 4-bit program counter. After reset it is in LOAD mode and accepts 16 program words. It then switches to RUN mode and executes one instruction per `timer555` rising edge.

---
 rtl/rr0.sv | 118 +++++++++++
 tb/tb_rr0.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr0.sv
// rr0: 4-bit accumulator processor with hand-loaded 16x8 program RAM and 16x4 data RAM.
// Optional halt instruction (opcode 0xF) is enabled by defining RR0_HALT_EN.
module rr0 #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  timer555,
   input  logic                  reset_count,
   input  logic [3:0]            A,
   output logic [3:0]            Acc,
   output logic [ADDR_WIDTH-1:0] counter,
   input  logic                  RAM_button,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] RAM_out,
   output logic [3:0]            RAM2_out
);

   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned ACC_W  = 4;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned IMM_W  = 4;

   localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
   localparam logic [OP_W-1:0] OP_IN   = 4'h4;
   localparam logic [OP_W-1:0] OP_ST   = 4'h5;
   localparam logic [OP_W-1:0] OP_LD   = 4'h6;
   localparam logic [OP_W-1:0] OP_JMP  = 4'h7;
   localparam logic [OP_W-1:0] OP_JZ   = 4'h8;
   localparam logic [OP_W-1:0] OP_JNZ  = 4'h9;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   typedef enum logic {
      MODE_LOAD = 1'b0,
      MODE_RUN  = 1'b1
   } mode_t;

   mode_t mode;
   logic  halted;

   logic [DATA_WIDTH-1:0] prog [DEPTH];
   logic [ACC_W-1:0]      data [DEPTH];

   logic [OP_W-1:0]       op;
   logic [IMM_W-1:0]      imm;
   logic [ACC_W-1:0]      acc_nxt;
   logic [ADDR_WIDTH-1:0] pc_nxt;
   logic                  halt_set;
   logic                  data_we;
   logic                  exec;

   // Instruction fetch and data read are purely combinational.
   assign RAM_out  = prog[counter];
   assign op       = RAM_out[DATA_WIDTH-1 -: OP_W];
   assign imm      = RAM_out[IMM_W-1:0];
   assign RAM2_out = data[ADDR_WIDTH'(imm)];

   assign exec = (mode == MODE_RUN) && !RAM_button && !halted;

   // Instruction decode: next accumulator, next counter, side effects.
   always_comb begin
      acc_nxt  = Acc;
      pc_nxt   = counter + ADDR_WIDTH'(1);
      halt_set = 1'b0;
      data_we  = 1'b0;
      case (op)
         OP_LDI:  acc_nxt = imm;
         OP_ADD:  acc_nxt = Acc + ACC_W'(imm);
         OP_SUB:  acc_nxt = Acc - ACC_W'(imm);
         OP_IN:   acc_nxt = A;
         OP_ST:   data_we = exec;
         OP_LD:   acc_nxt = RAM2_out;
         OP_JMP:  pc_nxt  = ADDR_WIDTH'(imm);
         OP_JZ:   if (Acc == '0) pc_nxt = ADDR_WIDTH'(imm);
         OP_JNZ:  if (Acc != '0) pc_nxt = ADDR_WIDTH'(imm);
`ifdef RR0_HALT_EN
         OP_HALT: begin
            halt_set = 1'b1;
            pc_nxt   = counter;
         end
`endif
         default: ;
      endcase
   end

   // Mode, counter and accumulator; writes advance the counter without executing.
   always_ff @(posedge timer555 or negedge reset_count) begin
      if (!reset_count) begin
         mode    <= MODE_LOAD;
         counter <= '0;
         Acc     <= '0;
      end else if (RAM_button) begin
         if (!halted) counter <= counter + ADDR_WIDTH'(1);
         if (mode == MODE_LOAD && counter == '1) mode <= MODE_RUN;
      end else if (exec) begin
         counter <= pc_nxt;
         Acc     <= acc_nxt;
      end
   end

`ifdef RR0_HALT_EN
   // Halt is sticky until reset; writes do not clear it.
   always_ff @(posedge timer555 or negedge reset_count) begin
      if (!reset_count) halted <= 1'b0;
      else if (exec && halt_set) halted <= 1'b1;
   end
`else
   assign halted = 1'b0;
`endif

   // RAMs are not reset so their contents survive a reset.
   always_ff @(posedge timer555) begin
      if (reset_count && RAM_button) prog[counter] <= data_in;
      if (reset_count && data_we) data[ADDR_WIDTH'(imm)] <= Acc;
   end

endmodule

// File: tb/tb_rr0.sv
// Directed self-checking bench for rr0: load, run arithmetic, branches, wrap, RUN writes, reset, halt.
module tb_rr0;

   logic       timer555;
   logic       reset_count;
   logic [3:0] A;
   logic [3:0] Acc;
   logic [3:0] counter;
   logic       RAM_button;
   logic [7:0] data_in;
   logic [7:0] RAM_out;
   logic [3:0] RAM2_out;

   int n_checks;
   int n_errors;
   logic [7:0] img [16];

   rr0 dut (
      .timer555   (timer555),
      .reset_count(reset_count),
      .A          (A),
      .Acc        (Acc),
      .counter    (counter),
      .RAM_button (RAM_button),
      .data_in    (data_in),
      .RAM_out    (RAM_out),
      .RAM2_out   (RAM2_out)
   );

   initial timer555 = 1'b0;
   always #5 timer555 = ~timer555;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge timer555);
      #1;
   endtask

   task automatic run_edge(input string tag, input logic [3:0] exp_acc, input logic [3:0] exp_ctr);
      RAM_button = 1'b0;
      tick();
      check({tag, "_acc"}, 8'(Acc), 8'(exp_acc));
      check({tag, "_ctr"}, 8'(counter), 8'(exp_ctr));
   endtask

   task automatic do_reset();
      RAM_button  = 1'b0;
      reset_count = 1'b0;
      #2;
      check("rst_ctr", 8'(counter), 8'h0);
      check("rst_acc", 8'(Acc), 8'h0);
      tick();
      check("rst_hold_ctr", 8'(counter), 8'h0);
      reset_count = 1'b1;
   endtask

   task automatic load_img();
      for (int i = 0; i < 16; i++) begin
         data_in    = img[i];
         RAM_button = 1'b1;
         tick();
         check("load_ctr", 8'(counter), 8'((i + 1) % 16));
      end
      RAM_button = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_count = 1'b0;
      RAM_button  = 1'b0;
      data_in     = 8'h00;
      A           = 4'h3;
      #3;
      do_reset();

      // LOAD idle edges leave the counter alone
      tick();
      check("idle_ctr0", 8'(counter), 8'h0);
      tick();
      check("idle_ctr1", 8'(counter), 8'h0);

      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      load_img();
      check("load_ram_out", RAM_out, 8'h00);
      run_edge("run_mode_nop", 4'h0, 4'h1);

      // RUN-mode writes: counter steps, Acc untouched
      data_in = 8'h17; RAM_button = 1'b1; tick();
      check("rw_ctr", 8'(counter), 8'h2);
      check("rw_acc", 8'(Acc), 8'h0);
      data_in = 8'h51; tick();
      data_in = 8'h70; tick();
      RAM_button = 1'b0;
      check("rw_ctr3", 8'(counter), 8'h4);
      for (int i = 0; i < 13; i++) tick();
      check("rw_wrap_ctr", 8'(counter), 8'h1);
      check("rw_readback", RAM_out, 8'h17);
      run_edge("setup_ldi", 4'h7, 4'h2);
      run_edge("setup_st", 4'h7, 4'h3);
      run_edge("setup_jmp", 4'h7, 4'h0);

      // Reset between edges acts without a clock
      #2;
      reset_count = 1'b0;
      #1;
      check("midrst_ctr", 8'(counter), 8'h0);
      check("midrst_acc", 8'(Acc), 8'h0);
      tick();
      reset_count = 1'b1;
      tick();
      check("midrst_load_idle", 8'(counter), 8'h0);

      // Arithmetic program; data[1]=7 survives the reset
      img = '{8'h40, 8'h21, 8'h22, 8'h50, 8'h61, 8'h60, 8'h70, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load_img();
      A = 4'h3;
      run_edge("in", 4'h3, 4'h1);
      run_edge("add1", 4'h4, 4'h2);
      run_edge("add2", 4'h6, 4'h3);
      run_edge("st", 4'h6, 4'h4);
      check("ram_out_ld1", RAM_out, 8'h61);
      check("ram2_data1", 8'(RAM2_out), 8'h07);
      run_edge("ld1", 4'h7, 4'h5);
      check("ram2_data0", 8'(RAM2_out), 8'h06);
      run_edge("ld0", 4'h6, 4'h6);
      run_edge("jmp", 4'h6, 4'h0);
      A = 4'h5;
      run_edge("in_again", 4'h5, 4'h1);

      // Branch and wraparound program
      do_reset();
      img = '{8'h10, 8'h85, 8'h00, 8'h00, 8'h00, 8'h12, 8'h8A, 8'h9A,
              8'h00, 8'h00, 8'h1F, 8'h21, 8'h31, 8'hF0, 8'hE3, 8'h00};
      load_img();
      run_edge("ldi0", 4'h0, 4'h1);
      run_edge("jz_taken", 4'h0, 4'h5);
      run_edge("ldi2", 4'h2, 4'h6);
      run_edge("jz_not", 4'h2, 4'h7);
      run_edge("jnz_taken", 4'h2, 4'hA);
      run_edge("ldiF", 4'hF, 4'hB);
      run_edge("add_wrap", 4'h0, 4'hC);
      run_edge("sub_wrap", 4'hF, 4'hD);
`ifdef RR0_HALT_EN
      for (int i = 0; i < 6; i++) run_edge("halt_freeze", 4'hF, 4'hD);
`else
      run_edge("op_f_nop", 4'hF, 4'hE);
      run_edge("op_e_nop", 4'hF, 4'hF);
      run_edge("ctr_wrap", 4'hF, 4'h0);
`endif
      do_reset();
      tick();
      check("final_idle_ctr", 8'(counter), 8'h0);
      check("final_acc", 8'(Acc), 8'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
